// File: rtl/mult_arb.sv
// mult_arb: four-requester round-robin arbiter in front of one shared external
// signed multiplier. One operation is in flight at a time. The FSM steps through
// IDLE (grant), MUL (one cycle for the external product) and RESP (hold the
// result until the owner accepts it).
//
// Ports
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   req_valid/req_a/req_b  per-requester request and packed signed operands
//   req_ready            one-hot combinational accept strobe (IDLE only)
//   rsp_valid/rsp_data   registered one-hot result valid and shared product
//   rsp_ready            per-requester result accept (only the owner's bit is used)
//   mul_a/mul_b/mul_out  registered operands to, and product from, the multiplier
//   busy                 high whenever the FSM is not idle
//   op_cnt               completed-operation count, wraps at 16 bits
module mult_arb #(
  parameter int unsigned WIDTH_A = 8,
  parameter int unsigned WIDTH_B = 8
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [3:0]                   req_valid,
  input  logic [4*WIDTH_A-1:0]         req_a,
  input  logic [4*WIDTH_B-1:0]         req_b,
  output logic [3:0]                   req_ready,
  output logic [3:0]                   rsp_valid,
  output logic [WIDTH_A+WIDTH_B-1:0]   rsp_data,
  input  logic [3:0]                   rsp_ready,
  output logic [WIDTH_A-1:0]           mul_a,
  output logic [WIDTH_B-1:0]           mul_b,
  input  logic [WIDTH_A+WIDTH_B-1:0]   mul_out,
  output logic                         busy,
  output logic [15:0]                  op_cnt
);

  localparam int unsigned P = WIDTH_A + WIDTH_B;

  typedef enum logic [1:0] {StIdle, StMul, StResp} state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         owner_q, owner_d;
  logic [WIDTH_A-1:0] mul_a_q, mul_a_d;
  logic [WIDTH_B-1:0] mul_b_q, mul_b_d;
  logic [P-1:0]       rsp_data_q, rsp_data_d;
  logic [3:0]         rsp_valid_q, rsp_valid_d;
  logic [15:0]        op_cnt_q, op_cnt_d;

  logic               gnt_found;
  logic [1:0]         gnt_idx;
  logic [1:0]         scan_idx;
  logic               accept;

  // Rotating priority: first valid requester at ptr, ptr+1, ... (2-bit wrap).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int unsigned k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Gated by reset so no accept strobe is shown while reset is asserted.
  assign accept = (state_q == StIdle) && gnt_found && !wb_rst_i;

  always_comb begin
    req_ready = 4'b0000;
    if (accept) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    op_cnt_d    = op_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mul_a_d = req_a[int'(gnt_idx)*WIDTH_A +: WIDTH_A];
          mul_b_d = req_b[int'(gnt_idx)*WIDTH_B +: WIDTH_B];
          owner_d = gnt_idx;
          ptr_d   = gnt_idx + 2'd1;
          state_d = StMul;
        end
      end
      StMul: begin
        rsp_data_d           = mul_out;
        rsp_valid_d          = 4'b0000;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = StResp;
      end
      StResp: begin
        // Only the owner's accept bit matters; the rest are ignored.
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = 4'b0000;
          op_cnt_d    = op_cnt_q + 16'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd0;
      owner_q     <= 2'd0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 4'b0000;
      op_cnt_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      op_cnt_q    <= op_cnt_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign op_cnt    = op_cnt_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/mult_arb.md
MULT_ARB -- requirements
Module: mult_arb

Interface
- REQ-001: Parameter WIDTH_A, default 8, signed operand A width, identical to the shared multiplier's A port.
- REQ-002: Parameter WIDTH_B, default 8, signed operand B width, identical to the shared multiplier's B port.
- REQ-003: Requester count is fixed at 4; P = WIDTH_A+WIDTH_B denotes the product width.
- REQ-004: wb_clk_i  in  1  the single clock; all state changes on its rising edge.
- REQ-005: wb_rst_i  in  1  reset, synchronous, active-high.
- REQ-006: req_valid  in  4  per-requester operation request.
- REQ-007: req_a  in  4*WIDTH_A  packed signed A operands, requester i at bits [i*WIDTH_A +: WIDTH_A].
- REQ-008: req_b  in  4*WIDTH_B  packed signed B operands, same packing.
- REQ-009: req_ready  out  4  one-hot accept strobe, combinational.
- REQ-010: rsp_valid  out  4  one-hot result-valid, registered.
- REQ-011: rsp_data  out  P  signed product shared by all requesters, registered.
- REQ-012: rsp_ready  in  4  per-requester result accept.
- REQ-013: mul_a / mul_b  out  WIDTH_A / WIDTH_B  registered operands to the external signed multiplier.
- REQ-014: mul_out  in  P  combinational signed product from the external multiplier.
- REQ-015: busy  out  1  high whenever state is not IDLE.
- REQ-016: op_cnt  out  16  completed-operation count.

Function
- REQ-017: FSM states are IDLE, MUL and RESP.
- REQ-018: In IDLE with any req_valid set, the grant is the first set requester scanning ptr, ptr+1, ... modulo 4.
- REQ-019: req_ready is asserted only in IDLE, only for the granted requester, and is zero in MUL and RESP.
- REQ-020: On accept (req_valid[g] & req_ready[g]) at edge T, the block registers req_a[g] and req_b[g] into mul_a and mul_b, stores owner=g, sets ptr=(g+1) mod 4, and enters MUL.
- REQ-021: MUL lasts exactly one cycle; at its closing edge rsp_data <= mul_out, rsp_valid[owner] <= 1, and the state becomes RESP.
- REQ-022: rsp_valid[owner] is first high in the second cycle after the accept cycle (fixed latency 2).
- REQ-023: In RESP, rsp_valid and rsp_data hold stable until rsp_ready[owner] is high; on that edge rsp_valid clears, op_cnt increments, and the state becomes IDLE.
- REQ-024: A new accept is never made in the same cycle as a response handshake, so the minimum issue interval is 3 cycles.
- REQ-025: rsp_ready bits of non-owners are ignored.
- REQ-026: req_valid bits of requesters other than the granted one are ignored and not latched.
- REQ-027: Dropping req_valid in IDLE before accept cancels that request with no side effect.
- REQ-028: mul_a and mul_b hold their last values outside the accept edge.
- REQ-029: The product is full width, signed, and never truncated or saturated.
- REQ-030: op_cnt wraps from 0xFFFF to 0x0000.

Reset
- REQ-031: While wb_rst_i is high at a clock edge, the next state is IDLE, with ptr=0, owner=0, mul_a=0, mul_b=0, rsp_data=0, rsp_valid=0 and op_cnt=0.
- REQ-032: During the reset cycle itself, req_ready=0.
- REQ-033: A reset in MUL or RESP aborts the operation: no rsp_valid is produced and op_cnt is not incremented.
- REQ-034: After reset the grant search starts at requester 0.

Verification
- REQ-035: Single request: req 2, a=-3, b=5, rsp_ready held high -> req_ready=0b0100 in the accept cycle; rsp_valid=0b0100 and rsp_data=0xFFF1 two cycles later; op_cnt=1.
- REQ-036: All four requesting continuously after reset -> grant order 0,1,2,3,0; each accept 3 cycles apart; rsp_valid one-hot matching the grantee.
- REQ-037: Extremes: -128*-128 -> rsp_data=0x4000; -128*127 -> 0xC080; 127*127 -> 0x3F01.
- REQ-038: Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=0, busy=1 throughout; release completes the operation once.
- REQ-039: Reset asserted in MUL -> next cycle rsp_valid=0, rsp_data=0, busy=0, op_cnt unchanged at 0; a following request from requester 3 with ptr=0 is granted to 3.
- REQ-040: op_cnt preloaded via 65535 operations -> the next completion reads 0x0000.
